// File: rtl/alu_seq.sv
// Multi-cycle ALU for a RiSC-16 style execute stage. It has six single-cycle
// operations, an iterative shift-add multiplier (MULL/MULH) and registered flags.
module alu_seq #(
    parameter int p_WORD_LEN = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    input  logic [2:0]            i_op,
    input  logic [p_WORD_LEN-1:0] i_ina,
    input  logic [p_WORD_LEN-1:0] i_inb,
    output logic                  o_ready,
    output logic                  o_valid,
    output logic [p_WORD_LEN-1:0] o_out,
    output logic                  o_eq,
    output logic                  o_zero,
    output logic                  o_carry
);

    localparam int W     = p_WORD_LEN;
    localparam int SH_W  = $clog2(W);
    localparam int CNT_W = SH_W + 1;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_NAND = 3'd1;
    localparam logic [2:0] OP_SUB  = 3'd2;
    localparam logic [2:0] OP_XOR  = 3'd3;
    localparam logic [2:0] OP_SHL  = 3'd4;
    localparam logic [2:0] OP_SHR  = 3'd5;
    localparam logic [2:0] OP_MULL = 3'd6;
    localparam logic [2:0] OP_MULH = 3'd7;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    state_t              state_r;
    logic                ready_r;
    logic                valid_r;
    logic [W-1:0]        out_r;
    logic                eq_r;
    logic                zero_r;
    logic                carry_r;

    logic [2*W-1:0]      mcand_r;
    logic [W-1:0]        mplier_r;
    logic [2*W-1:0]      acc_r;
    logic [CNT_W-1:0]    cnt_r;
    logic                mulh_r;
    logic                eq_pend_r;

    logic [W:0]          sum_s;
    logic [SH_W-1:0]     shamt_s;
    logic [W-1:0]        alu_res_s;
    logic                alu_carry_s;
    logic                mul_op_s;
    logic [2*W-1:0]      acc_next_s;
    logic [W-1:0]        mul_res_s;
    logic                last_iter_s;

    // Single-cycle datapath, evaluated on the live request inputs
    always_comb begin
        sum_s       = {1'b0, i_ina} + {1'b0, i_inb};
        shamt_s     = i_inb[SH_W-1:0];
        alu_res_s   = '0;
        alu_carry_s = 1'b0;
        case (i_op)
            OP_ADD: begin
                alu_res_s   = sum_s[W-1:0];
                alu_carry_s = sum_s[W];
            end
            OP_NAND: alu_res_s = ~(i_ina & i_inb);
            OP_SUB: begin
                alu_res_s   = i_ina - i_inb;
                alu_carry_s = (i_ina < i_inb);
            end
            OP_XOR:  alu_res_s = i_ina ^ i_inb;
            OP_SHL:  alu_res_s = i_ina << shamt_s;
            OP_SHR:  alu_res_s = i_ina >> shamt_s;
            default: begin
                alu_res_s   = '0;
                alu_carry_s = 1'b0;
            end
        endcase
    end

    // Multiplier step; the final iteration's partial product is folded in
    // here so the result can be registered on the same edge
    always_comb begin
        mul_op_s    = (i_op == OP_MULL) || (i_op == OP_MULH);
        acc_next_s  = mplier_r[0] ? (acc_r + mcand_r) : acc_r;
        mul_res_s   = mulh_r ? acc_next_s[2*W-1:W] : acc_next_s[W-1:0];
        last_iter_s = (cnt_r == CNT_W'(W - 1));
    end

    // Control FSM with registered result, flags and handshake outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r   <= ST_IDLE;
            ready_r   <= 1'b1;
            valid_r   <= 1'b0;
            out_r     <= '0;
            eq_r      <= 1'b0;
            zero_r    <= 1'b0;
            carry_r   <= 1'b0;
            mcand_r   <= '0;
            mplier_r  <= '0;
            acc_r     <= '0;
            cnt_r     <= '0;
            mulh_r    <= 1'b0;
            eq_pend_r <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (i_valid && mul_op_s) begin
                        mcand_r   <= {{W{1'b0}}, i_ina};
                        mplier_r  <= i_inb;
                        acc_r     <= '0;
                        cnt_r     <= '0;
                        mulh_r    <= (i_op == OP_MULH);
                        eq_pend_r <= (i_ina == i_inb);
                        ready_r   <= 1'b0;
                        state_r   <= ST_MUL;
                    end else if (i_valid) begin
                        out_r   <= alu_res_s;
                        eq_r    <= (i_ina == i_inb);
                        zero_r  <= (alu_res_s == '0);
                        carry_r <= alu_carry_s;
                        valid_r <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_MUL: begin
                    acc_r    <= acc_next_s;
                    mcand_r  <= mcand_r << 1'b1;
                    mplier_r <= mplier_r >> 1'b1;
                    cnt_r    <= cnt_r + CNT_W'(1);
                    if (last_iter_s) begin
                        out_r   <= mul_res_s;
                        eq_r    <= eq_pend_r;
                        zero_r  <= (mul_res_s == '0);
                        carry_r <= 1'b0;
                        valid_r <= 1'b1;
                        ready_r <= 1'b1;
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_MUL;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign o_ready = ready_r;
    assign o_valid = valid_r;
    assign o_out   = out_r;
    assign o_eq    = eq_r;
    assign o_zero  = zero_r;
    assign o_carry = carry_r;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed table, hand-written multi-cycle
// sequences and randomized ops against an arithmetic reference model.
module tb_alu_seq;

    localparam int W = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        v;
    logic [2:0]  op;
    logic [15:0] a, b;
    logic        ready, valid, eq, zero, carry;
    logic [15:0] out;

    logic        v32;
    logic [2:0]  op32;
    logic [31:0] a32, b32;
    logic        ready32, valid32, eq32, zero32, carry32;
    logic [31:0] out32;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_seq #(.p_WORD_LEN(16)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(v), .i_op(op), .i_ina(a), .i_inb(b),
        .o_ready(ready), .o_valid(valid), .o_out(out), .o_eq(eq), .o_zero(zero), .o_carry(carry)
    );

    alu_seq #(.p_WORD_LEN(32)) dut32 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(v32), .i_op(op32), .i_ina(a32), .i_inb(b32),
        .o_ready(ready32), .o_valid(valid32), .o_out(out32), .o_eq(eq32), .o_zero(zero32),
        .o_carry(carry32)
    );

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp_out;
        logic        exp_c;
        logic        exp_e;
        logic        exp_z;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    // Reference: plain unsigned arithmetic on wide integers, masked to w bits
    task automatic model(input int w, input logic [2:0] mop, input logic [31:0] ma,
                         input logic [31:0] mb, output logic [31:0] mo, output logic mc,
                         output logic me, output logic mz);
        longint unsigned mask, x, y, r, p;
        mask = (64'd1 << w) - 64'd1;
        x = 64'(ma);
        y = 64'(mb);
        mc = 1'b0;
        p  = x * y;
        case (mop)
            3'd0: begin r = x + y; mc = r[w]; end
            3'd1: r = ~(x & y);
            3'd2: begin r = x - y; mc = (x < y); end
            3'd3: r = x ^ y;
            3'd4: r = x << (y % 64'(w));
            3'd5: r = x >> (y % 64'(w));
            3'd6: r = p;
            default: r = p >> w;
        endcase
        r  = r & mask;
        mo = r[31:0];
        me = (ma == mb);
        mz = (r == 64'd0);
    endtask

    // Issue one op on the 16-bit unit and check result, flags, latency, pulse width
    task automatic run16(input logic [2:0] top, input logic [15:0] ta, input logic [15:0] tb,
                         input logic [15:0] eo, input logic ec, input logic ee, input logic ez,
                         input string tag, input bit noise);
        int  cnt;
        bit  busy_hi;
        @(negedge clk);
        chk({tag, " ready_before"}, 32'(ready), 32'd1);
        v = 1'b1; op = top; a = ta; b = tb;
        @(posedge clk); #1;
        v = 1'b0; a = 16'($urandom); b = 16'($urandom);
        if (top < 3'd6) begin
            chk({tag, " valid"}, 32'(valid), 32'd1);
        end else begin
            cnt = 0;
            busy_hi = 1'b0;
            chk({tag, " ready_busy"}, 32'(ready), 32'd0);
            while (!valid && cnt < 64) begin
                if (noise) begin
                    @(negedge clk);
                    v = 1'($urandom); op = 3'd0; a = 16'($urandom); b = 16'($urandom);
                end
                @(posedge clk); #1;
                cnt++;
                if (ready && !valid) busy_hi = 1'b1;
            end
            v = 1'b0;
            chk({tag, " latency"}, 32'(cnt), 32'(W));
            chk({tag, " ready_low_whole_window"}, 32'(busy_hi), 32'd0);
            chk({tag, " ready_after"}, 32'(ready), 32'd1);
        end
        chk({tag, " out"}, 32'(out), 32'(eo));
        chk({tag, " carry"}, 32'(carry), 32'(ec));
        chk({tag, " eq"}, 32'(eq), 32'(ee));
        chk({tag, " zero"}, 32'(zero), 32'(ez));
        @(posedge clk); #1;
        chk({tag, " single_pulse"}, 32'(valid), 32'd0);
    endtask

    vec_t tbl[12];

    initial begin
        int cnt;
        int seen;
        logic [31:0] mo;
        logic mc, me, mz;
        logic [2:0] rop;
        logic [15:0] ra, rb;

        tbl[0]  = '{3'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1};
        tbl[1]  = '{3'd4, 16'h8001, 16'h0004, 16'h0010, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{3'd5, 16'h8001, 16'h000F, 16'h0001, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{3'd3, 16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b1, 1'b1};
        tbl[4]  = '{3'd6, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{3'd7, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{3'd2, 16'h0005, 16'h0005, 16'h0000, 1'b0, 1'b1, 1'b1};
        tbl[7]  = '{3'd1, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b1};
        tbl[8]  = '{3'd7, 16'h0000, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{3'd4, 16'h0001, 16'h0011, 16'h0002, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{3'd0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{3'd2, 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b0};

        rst_n = 1'b0;
        v = 1'b0; op = 3'd0; a = 16'h0; b = 16'h0;
        v32 = 1'b0; op32 = 3'd0; a32 = 32'h0; b32 = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset ready", 32'(ready), 32'd1);
        chk("reset valid", 32'(valid), 32'd0);
        chk("reset out", 32'(out), 32'd0);
        chk("reset flags", {29'd0, eq, zero, carry}, 32'd0);

        for (int i = 0; i < 12; i++) begin
            run16(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp_out, tbl[i].exp_c, tbl[i].exp_e,
                  tbl[i].exp_z, $sformatf("tbl[%0d]", i), 1'b1);
        end

        // NAND then SUB back-to-back with i_valid held high
        @(negedge clk);
        v = 1'b1; op = 3'd1; a = 16'hF0F0; b = 16'hFF00;
        @(posedge clk); #1;
        chk("b2b nand valid", 32'(valid), 32'd1);
        chk("b2b nand out", 32'(out), 32'h0FFF);
        chk("b2b ready", 32'(ready), 32'd1);
        @(negedge clk);
        op = 3'd2; a = 16'h0003; b = 16'h0005;
        @(posedge clk); #1;
        v = 1'b0;
        chk("b2b sub valid", 32'(valid), 32'd1);
        chk("b2b sub out", 32'(out), 32'hFFFE);
        chk("b2b sub carry", 32'(carry), 32'd1);
        chk("b2b ready2", 32'(ready), 32'd1);
        @(posedge clk); #1;
        chk("b2b valid_drop", 32'(valid), 32'd0);

        // Reset five clocks into a MULL: outputs return to reset values, no late result
        run16(3'd0, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b1, 1'b0, "pre_rst add", 1'b0);
        @(negedge clk);
        v = 1'b1; op = 3'd6; a = 16'h1234; b = 16'h5678;
        @(posedge clk); #1;
        v = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst ready", 32'(ready), 32'd1);
        chk("midrst valid", 32'(valid), 32'd0);
        chk("midrst out", 32'(out), 32'd0);
        chk("midrst flags", {29'd0, eq, zero, carry}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (24) begin
            @(posedge clk); #1;
            if (valid) seen++;
        end
        chk("midrst no_valid", 32'(seen), 32'd0);
        run16(3'd0, 16'h0002, 16'h0003, 16'h0005, 1'b0, 1'b0, 1'b0, "post_rst add", 1'b0);

        // Randomized ops against the reference model
        for (int i = 0; i < 60; i++) begin
            rop = 3'($urandom_range(7, 0));
            ra  = 16'($urandom);
            rb  = (i % 7 == 0) ? ra : 16'($urandom);
            model(16, rop, 32'(ra), 32'(rb), mo, mc, me, mz);
            run16(rop, ra, rb, mo[15:0], mc, me, mz, $sformatf("rnd[%0d] op%0d", i, rop),
                  1'($urandom));
        end

        // 32-bit instance: MULH and ADD wrap
        @(negedge clk);
        v32 = 1'b1; op32 = 3'd7; a32 = 32'h0001_0000; b32 = 32'h0001_0000;
        @(posedge clk); #1;
        v32 = 1'b0; a32 = 32'hDEAD_BEEF; b32 = 32'h0;
        cnt = 0;
        while (!valid32 && cnt < 100) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("w32 mulh latency", 32'(cnt), 32'd32);
        chk("w32 mulh out", out32, 32'h0000_0001);
        chk("w32 mulh zero", 32'(zero32), 32'd0);
        @(negedge clk);
        v32 = 1'b1; op32 = 3'd0; a32 = 32'h8000_0000; b32 = 32'h8000_0000;
        @(posedge clk); #1;
        v32 = 1'b0;
        chk("w32 add valid", 32'(valid32), 32'd1);
        chk("w32 add out", out32, 32'h0);
        chk("w32 add carry", 32'(carry32), 32'd1);
        chk("w32 add zero", 32'(zero32), 32'd1);
        chk("w32 add eq", 32'(eq32), 32'd1);
        chk("w32 ready", 32'(ready32), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised multi-cycle ALU for the pipelined RiSC-16 execute stage and its wider derivatives. It extends the single-cycle add/nand unit to an eight-operation unit with registered results, status flags, and an iterative unsigned shift-add multiplier. A valid/ready handshake sequences the operations. Single-cycle operations complete in one clock; multiply operations hold the unit busy for `p_WORD_LEN` clocks.

## Interface
- Clocking: one clock; reset is asynchronous and active-low (`i_clk`, `i_rst_n`).
- `p_WORD_LEN`, default 16: operand/result width; must be a power of two ≥ 4.
- `i_clk` input 1: clock; all state updates on its rising edge.
- `i_rst_n` input 1: asynchronous active-low reset.
- `i_valid` input 1: operation request; accepted only when `o_ready`=1.
- `i_op` input 3: opcode. 0 ADD, 1 NAND, 2 SUB, 3 XOR, 4 SHL, 5 SHR, 6 MULL, 7 MULH.
- `i_ina` input `p_WORD_LEN`: operand A.
- `i_inb` input `p_WORD_LEN`: operand B; the shift amount is its low $clog2(`p_WORD_LEN`) bits.
- `o_ready` output 1: unit idle and able to accept a request.
- `o_valid` output 1: one-cycle pulse; result and flags are valid in this cycle.
- `o_out` output `p_WORD_LEN`: registered result.
- `o_eq` output 1: the accepted operands were equal (A == B).
- `o_zero` output 1: `o_out` == 0.
- `o_carry` output 1: ADD carry-out, or SUB borrow (A < B unsigned); 0 for all other ops.

## Operation
- States:
  - IDLE: `o_ready`=1.
  - MUL: `o_ready`=0.
- Accept: a rising edge with `o_ready`=1 and `i_valid`=1.
  - Opcode and operands are captured at accept.
  - Later changes on the inputs have no effect on that operation.
- IDLE, accept of op 0–5:
  - The result is computed and registered at the accept edge.
  - `o_valid`=1 for the following cycle; state stays IDLE.
- IDLE, accept of op 6/7:
  - Load the multiplicand (A), multiplier (B), a 2·W-bit accumulator cleared to 0, and a bit counter of $clog2(W)+1 bits cleared to 0.
  - Go to MUL.
- MUL, each edge:
  - If the multiplier LSB = 1, add the shifted multiplicand into the accumulator.
  - Shift the multiplicand left 1 and the multiplier right 1; increment the counter.
  - On the edge where counter == W−1 (the W-th iteration), register the final result: MULL returns product[W−1:0], MULH returns product[2W−1:W].
  - On that same edge, pulse `o_valid` and return to IDLE.
- Arithmetic, all unsigned and modulo 2^W:
  - ADD: A+B; `o_carry` = bit W of the W+1-bit sum.
  - SUB: A−B; `o_carry` = 1 when A < B.
  - NAND: ~(A&B). XOR: A^B.
  - SHL / SHR: logical shift of A, zero fill, by amount 0..W−1.
- Flags are registered together with `o_out`. `o_zero` is evaluated on the selected result (the selected half for MULL/MULH).
- `o_out`, `o_eq`, `o_zero` and `o_carry` hold their last values until the next completion.
- `i_valid` while `o_ready`=0 is ignored. The request is not queued; the requester must hold or reissue it.
- A new request may be accepted in the cycle `o_valid`=1, since the unit is back in IDLE.
- Unused multiplier state is don't-care in IDLE.

## Timing
- Reset values:
  - `o_ready`=1, `o_valid`=0, `o_out`=0, `o_eq`=0, `o_zero`=0, `o_carry`=0.
  - State IDLE; counter 0.
- Latency, ops 0–5: accept at edge N, `o_valid` high from N until N+1.
  - Throughput is one op per clock with `i_valid` held high.
- Latency, ops 6/7: accept at edge N.
  - `o_ready`=0 from N to N+W.
  - The result and `o_valid` are registered at edge N+W; `o_ready`=1 from edge N+W.
- Reset asserted mid-MUL: immediate return to IDLE with reset values. The abandoned op never produces `o_valid`.
- `o_valid` is never high for two consecutive cycles unless two consecutive single-cycle ops were accepted.

## Test plan
- ADD: A=0xFFFF, B=0x0001 → `o_out`=0x0000, `o_carry`=1, `o_zero`=1, `o_eq`=0. `o_valid` is a single pulse one clock after accept.
- NAND then SUB back-to-back:
  - NAND 0xF0F0, 0xFF00 → 0x0FFF.
  - Next cycle, SUB 0x0003, 0x0005 → 0xFFFE, `o_carry`=1.
  - Consecutive `o_valid` pulses, `o_ready` stays 1.
- Shifts and XOR:
  - SHL A=0x8001, B=0x0004 → 0x0010.
  - SHR A=0x8001, B=0x000F → 0x0001.
  - XOR 0x1234, 0x1234 → 0x0000, `o_eq`=1, `o_zero`=1.
- Multiply 0xFFFF×0xFFFF:
  - MULL → 0x0001; MULH → 0xFFFE.
  - Each holds `o_ready`=0 for exactly 16 clocks.
  - During the busy window, `i_valid` pulses with op ADD and operand changes are ignored and do not alter the result.
- Reset mid-MUL: deassert `i_rst_n` 5 clocks after a MULL accept → all outputs at reset values, no `o_valid` afterwards. A following ADD 2+3 → 0x0005 after one clock.
- `p_WORD_LEN`=32: MULH 0x0001_0000×0x0001_0000 → 0x0000_0001 after 32 clocks. ADD 0x8000_0000+0x8000_0000 → 0, `o_carry`=1.
